writeback_queue: RTL
====================

// Module: writeback_queue
// PURPOSE
//  Write-side initiator for the 16x16 register file: accepts result writes from the
//  execute/memory stages over a valid/ready handshake and buffers them in a small FIFO.
//  Drains one entry per cycle onto the register file write port (reg_write/write_reg/write_data).
//  Publishes a pending-write mask so decode can stall on RAW hazards until data is committed.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >= 2
//  DATA_W  16  write data width; matches register file word
//  ADDR_W  4   register index width; mask width is 2**ADDR_W
// PORTS
//  clk            in   1             rising-edge clock
//  rst            in   1             synchronous, active-high reset
//  in_valid       in   1             producer has a write request
//  in_ready       out  1             queue can accept; = (count < DEPTH)
//  in_reg         in   ADDR_W        destination register
//  in_data        in   DATA_W        write data
//  hold           in   1             1 = do not pop this cycle
//  flush          in   1             discard all queued and staged writes
//  rf_write       out  1             to register file reg_write
//  rf_write_reg   out  ADDR_W        to register file write_reg
//  rf_write_data  out  DATA_W        to register file write_data
//  query_reg      in   ADDR_W        register being checked by decode
//  query_busy     out  1             = pending_mask[query_reg]
//  pending_mask   out  2**ADDR_W     bit r set while a write to r is queued or staged
//  count          out  $clog2(DEPTH)+1  FIFO occupancy, excludes output stage
// BEHAVIOUR
//  - Reset (rst=1 at edge): count=0, rd/wr pointers=0, rf_write=0, rf_write_reg=0,
//    rf_write_data=0; pending_mask=0 and in_ready=1 in the following cycle.
//    rst overrides flush, push, and pop.
//  - Push: in_valid & in_ready & !flush at edge -> {in_reg,in_data} written at wr_ptr, wr_ptr++.
//    in_ready depends only on count. There is no same-cycle pop credit: at count=DEPTH,
//    in_ready=0 even if a pop occurs in that cycle.
//  - Pop: !hold & !flush & count>0 at edge -> head loaded into rf_write_reg/rf_write_data,
//    rf_write<=1, rd_ptr++. Otherwise rf_write<=0; reg/data hold their last values.
//  - Latency: push at edge N -> rf_write=1 during cycle N+1..N+2 -> register file commits at edge N+2.
//    Sustained throughput is 1 write per cycle.
//  - Push and pop at the same edge: count is unchanged. Pointers wrap modulo DEPTH.
//  - FIFO order is preserved. Repeated writes to the same register all reach the
//    register file, in order.
//  - Flush at edge: count<=0, pointers<=0, rf_write<=0; a push presented in the same
//    cycle is dropped.
//  - pending_mask is combinational from registered state: OR of onehot(reg) over valid
//    FIFO entries, plus onehot(rf_write_reg) when rf_write=1. A bit clears in the cycle
//    after the register file write edge.
//  - hold=1 with count=0: no effect. hold does not block push.
//  - No register is special-cased: writes to r0 are queued and committed like any other.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> rf_write=0, count=0, pending_mask=0,
//    in_ready=1.
//  2 Single: push reg=3, data=16'hBEEF at edge1 -> pending_mask=16'h0008 after edge1;
//    rf_write=1, reg=3, data=BEEF after edge2; mask=0, rf_write=0 after edge3.
//  3 Full: hold=1, push regs 1,2,3,4 -> count=4, in_ready=0; a 5th push (reg 5) is
//    ignored; mask=16'h001E; release hold -> 4 consecutive rf_write pulses, regs 1,2,3,4.
//  4 Streaming: push every cycle with hold=0 -> count stays 1 and rf_write stays high;
//    data order matches input order; query_reg=7 gives query_busy=1 only while reg 7
//    is queued or staged.
//  5 Flush: count=3, rf_write=1, flush=1 with in_valid=1 -> next cycle count=0,
//    rf_write=0, pending_mask=0, and the pushed entry never appears.
//  6 Mid-run reset: rst asserted while count=2 and hold=0 -> no rf_write after that edge;
//    a subsequent push of reg 9 follows the scenario 2 timing.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: buffers register-file writes in a FIFO and drains one per cycle onto the write port.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       rf_write,
  output logic [ADDR_W-1:0]          rf_write_reg,
  output logic [DATA_W-1:0]          rf_write_data,
  input  logic [ADDR_W-1:0]          query_reg,
  output logic                       query_busy,
  output logic [2**ADDR_W-1:0]       pending_mask,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign in_ready = count < CW'(DEPTH);
  assign push = in_valid & in_ready & ~flush;
  assign pop = ~hold & ~flush & (count != '0);
  assign query_busy = pending_mask[query_reg];
  // Walk only the occupied slots, starting at the head, so stale entries never mark a register busy.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < count) pending_mask[mem_reg[rd_ptr + PW'(k)]] = 1'b1;
    if (rf_write) pending_mask[rf_write_reg] = 1'b1;
  end
  always_ff @(posedge clk)
    if (push && !rst) begin
      mem_reg[wr_ptr] <= in_reg;
      mem_data[wr_ptr] <= in_data;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      rf_write <= 1'b0;
      rf_write_reg <= '0;
      rf_write_data <= '0;
    end else if (flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      rf_write <= 1'b0;
    end else begin
      rf_write <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rf_write_reg <= mem_reg[rd_ptr];
        rf_write_data <= mem_data[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
